// File: rtl/friscv_uart_tx_if.sv
// rtl/friscv_uart_tx_if.sv - byte push handshake into the UART transmit FIFO
interface friscv_uart_tx_if;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] data;

    modport master (output data_valid, output data, input data_ready);
    modport slave  (input data_valid, input data, output data_ready);
endinterface

// File: rtl/friscv_uart_tx.sv
// rtl/friscv_uart_tx.sv - 8N1 UART transmitter with byte FIFO and CTS flow control
module friscv_uart_tx #(
    parameter int CLK_DIVIDER = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              srst,
    friscv_uart_tx_if.slave   push,
    output logic              uart_tx,
    input  logic              uart_cts,
    output logic              busy,
    output logic              fifo_empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIVIDER);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW:0]     wr_ptr, rd_ptr;
    logic [7:0]      shift_reg, shift_nxt;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic            fifo_full, push_en, pop, bit_done, frame_go, tx_nxt;

    // Pointer MSBs differ with equal index bits only when the FIFO is full.
    assign fifo_empty      = (wr_ptr == rd_ptr);
    assign fifo_full       = ((wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}});
    assign push.data_ready = !fifo_full;
    assign push_en         = push.data_valid && !fifo_full;
    assign bit_done        = (baud_cnt == CW'(CLK_DIVIDER - 1));
    assign frame_go        = !fifo_empty && uart_cts;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else if (srst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (frame_go) state_nxt = S_START;
            S_START: if (bit_done) state_nxt = S_DATA;
            S_DATA:  if (bit_done && bit_cnt == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (bit_done) state_nxt = frame_go ? S_START : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The line level is computed for the state being entered so uart_tx can be registered.
    always_comb begin
        busy      = (state != S_IDLE);
        pop       = frame_go && ((state == S_IDLE) || (state == S_STOP && bit_done));
        shift_nxt = shift_reg;
        if (pop)
            shift_nxt = mem[rd_ptr[PW-1:0]];
        else if (state == S_DATA && bit_done)
            shift_nxt = {1'b0, shift_reg[7:1]};
        case (state_nxt)
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            shift_reg <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            uart_tx   <= 1'b1;
        end else if (srst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            shift_reg <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            uart_tx   <= 1'b1;
        end else begin
            if (push_en)
                wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PW+1)'(1);
            shift_reg <= shift_nxt;
            uart_tx   <= tx_nxt;
            if (state_nxt != state || state == S_IDLE || bit_done)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + CW'(1);
            if (state_nxt != state)
                bit_cnt <= '0;
            else if (state == S_DATA && bit_done)
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push_en)
            mem[wr_ptr[PW-1:0]] <= push.data;
    end

endmodule

// File: tb/tb_friscv_uart_tx.sv
// tb/tb_friscv_uart_tx.sv - scoreboard bench for friscv_uart_tx
module tb_friscv_uart_tx;

    localparam int DIV = 8;

    logic aclk, areset, srst, uart_tx, uart_cts, busy, fifo_empty;
    int   cyc, checks, failures;
    logic [7:0] sb[$];
    int   start_q[$];

    friscv_uart_tx_if bus ();

    friscv_uart_tx #(.CLK_DIVIDER(DIV), .FIFO_DEPTH(4)) dut (
        .aclk(aclk), .areset(areset), .srst(srst), .push(bus.slave),
        .uart_tx(uart_tx), .uart_cts(uart_cts), .busy(busy), .fifo_empty(fifo_empty)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, output logic acc);
        @(negedge aclk);
        bus.data_valid = 1'b1;
        bus.data       = b;
        acc            = bus.data_ready;
        @(posedge aclk);
        #1 bus.data_valid = 1'b0;
        if (acc) sb.push_back(b);
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string nm);
        int n = 0;
        while (busy !== lvl && n < max) begin
            @(negedge aclk);
            n++;
        end
        chk(nm, busy, lvl);
    endtask

    task automatic quiet(input int n, input string nm);
        int viol = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk(nm, viol, 0);
    endtask

    task automatic gaps_ok(input int n, input string nm);
        int bad = 0;
        if (start_q.size() != n) bad = 1;
        else for (int i = 1; i < n; i++)
            if (start_q[i] - start_q[i-1] != 10*DIV) bad++;
        chk(nm, bad, 0);
    endtask

    // Monitor: decodes each frame sampling every cycle, checks bit widths, pops scoreboard.
    initial begin : monitor
        logic [9:0] val;
        logic       ok, aborted;
        logic [7:0] exp;
        forever begin
            @(negedge aclk);
            if (!(areset || srst) && uart_tx === 1'b0) begin
                start_q.push_back(cyc);
                ok = 1'b1;
                aborted = 1'b0;
                val = '0;
                for (int i = 0; i < 10*DIV; i++) begin
                    if (i > 0) @(negedge aclk);
                    if (areset || srst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i % DIV == 0) val[i/DIV] = uart_tx;
                    else if (uart_tx !== val[i/DIV]) ok = 1'b0;
                end
                if (!aborted) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL frame_unexpected actual=%0h expected=none", val[8:1]);
                    end else begin
                        exp = sb.pop_front();
                        if (!ok || val[0] !== 1'b0 || val[9] !== 1'b1 || val[8:1] !== exp) begin
                            failures++;
                            $display("FAIL frame actual=%0h (framing_ok=%0b start=%0b stop=%0b) expected=%0h",
                                     val[8:1], ok, val[0], val[9], exp);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        logic acc;
        logic [4:0] accs;
        int n;
        cyc = 0; checks = 0; failures = 0;
        areset = 1'b1; srst = 1'b0; uart_cts = 1'b1;
        bus.data_valid = 1'b0; bus.data = '0;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_data_ready", bus.data_ready, 1);

        // Single byte 0xA5
        push_byte(8'hA5, acc);
        chk("single_fifo_empty_after_push", fifo_empty, 0);
        @(negedge aclk);
        chk("single_busy_before_start", busy, 0);
        @(negedge aclk);
        chk("single_start_bit", uart_tx, 0);
        chk("single_busy_rise", busy, 1);
        n = 1;
        while (n < 200) begin
            @(negedge aclk);
            if (busy) n++; else break;
        end
        chk("single_busy_cycles", n, 80);
        chk("single_fifo_empty_after", fifo_empty, 1);
        repeat (2) @(negedge aclk);
        chk("single_sb_drained", sb.size(), 0);

        // Flow-control hold and fill
        uart_cts = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'(i + 1), acc);
            accs[i] = acc;
        end
        chk("fill_accepts", accs, 5'b01111);
        chk("fill_data_ready", bus.data_ready, 0);
        quiet(20, "fill_line_hold");
        start_q.delete();
        uart_cts = 1'b1;
        wait_busy(1, 5, "fill_busy_rise");
        repeat (2) @(negedge aclk);
        chk("fill_ready_after_pop", bus.data_ready, 1);
        wait_busy(0, 400, "fill_busy_fall");
        repeat (3) @(negedge aclk);
        gaps_ok(4, "fill_back_to_back");
        chk("fill_sb_drained", sb.size(), 0);

        // CTS drop mid-frame
        push_byte(8'h3C, acc);
        push_byte(8'hC3, acc);
        wait_busy(1, 5, "cts_busy_rise");
        repeat (36) @(negedge aclk);
        uart_cts = 1'b0;
        wait_busy(0, 100, "cts_first_done");
        quiet(20, "cts_hold");
        chk("cts_still_queued", fifo_empty, 0);
        chk("cts_sb_one_left", sb.size(), 1);
        uart_cts = 1'b1;
        wait_busy(1, 5, "cts_resume_rise");
        wait_busy(0, 100, "cts_resume_fall");
        repeat (3) @(negedge aclk);
        chk("cts_sb_drained", sb.size(), 0);

        // Simultaneous push and pop at the STOP->START edge
        uart_cts = 1'b0;
        push_byte(8'h11, acc);
        push_byte(8'h22, acc);
        push_byte(8'h33, acc);
        start_q.delete();
        @(negedge aclk);
        uart_cts = 1'b1;
        wait_busy(1, 5, "simul_busy_rise");
        repeat (79) @(negedge aclk);
        chk("simul_ready_before", bus.data_ready, 1);
        bus.data_valid = 1'b1;
        bus.data = 8'h44;
        @(posedge aclk);
        #1 bus.data_valid = 1'b0;
        sb.push_back(8'h44);
        chk("simul_ready_after", bus.data_ready, 1);
        chk("simul_busy_after", busy, 1);
        wait_busy(0, 400, "simul_busy_fall");
        repeat (3) @(negedge aclk);
        gaps_ok(4, "simul_back_to_back");
        chk("simul_sb_drained", sb.size(), 0);

        // Async reset mid-frame
        push_byte(8'h55, acc);
        push_byte(8'h66, acc);
        push_byte(8'h77, acc);
        repeat (25) @(negedge aclk);
        #2 areset = 1'b1;
        #1;
        chk("areset_uart_tx", uart_tx, 1);
        chk("areset_busy", busy, 0);
        chk("areset_fifo_empty", fifo_empty, 1);
        chk("areset_data_ready", bus.data_ready, 1);
        sb.delete();
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        quiet(100, "areset_no_frame");

        // Synchronous reset mid-frame
        push_byte(8'h55, acc);
        push_byte(8'h66, acc);
        push_byte(8'h77, acc);
        repeat (25) @(negedge aclk);
        #2 srst = 1'b1;
        #1;
        chk("srst_busy_before_edge", busy, 1);
        @(posedge aclk);
        #1;
        chk("srst_uart_tx", uart_tx, 1);
        chk("srst_busy", busy, 0);
        chk("srst_fifo_empty", fifo_empty, 1);
        sb.delete();
        @(negedge aclk);
        #2 srst = 1'b0;
        quiet(40, "srst_no_frame");
        push_byte(8'h80, acc);
        wait_busy(1, 5, "srst_new_rise");
        wait_busy(0, 100, "srst_new_fall");
        repeat (3) @(negedge aclk);
        chk("srst_sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/friscv_uart_tx.md
# friscv_uart_tx

UART transmit engine for the friscv peripheral set. It accepts bytes over a valid/ready push interface and buffers them in a small FIFO. Each byte is serialised on `uart_tx` as an 8N1 frame, LSB first, with CTS flow control. It is the transmitting counterpart to the receive path that the `uart_vpi` bench model and the core's UART sample, and is clocked from the same `aclk` domain.

## Interface
- `CLK_DIVIDER`, 8: `aclk` cycles per UART bit. Must be ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO depth. Must be a power of 2 and ≥ 2.
- `aclk` in 1: the single clock.
- `areset` in 1: reset, asynchronous, active-high.
- `srst` in 1: synchronous reset, active-high. Same effect as `areset`, applied on the `aclk` edge.
- `data_valid` in 1: push request.
- `data_ready` out 1: FIFO can accept a byte. Equals `!full`.
- `data` in 8: byte to transmit.
- `uart_tx` out 1: serial line. Idles high.
- `uart_cts` in 1: peer clear-to-send, active-high. 1 = frame start allowed.
- `busy` out 1: a frame is on the line (state ≠ IDLE).
- `fifo_empty` out 1: FIFO holds no byte.

## Operation
- Push: a byte is written when `data_valid && data_ready` on a rising `aclk` edge.
- Full FIFO: `data_ready` is 0 even if a pop happens in the same cycle. There is no same-cycle push-through when full.
- Pointer widths: pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally, and the MSB distinguishes full from empty.
- FSM states: IDLE, START, DATA, STOP.
- IDLE → START when `!fifo_empty && uart_cts`. This transition pops the FIFO head into an 8-bit shift register.
- START: `uart_tx` = 0 for CLK_DIVIDER cycles, then go to DATA.
- DATA: drive shift register bit 0, shifting right every CLK_DIVIDER cycles. A 3-bit bit counter runs 0..7. After bit 7 completes, go to STOP.
- STOP: `uart_tx` = 1 for CLK_DIVIDER cycles.
- End of STOP: if `!fifo_empty && uart_cts`, go straight to START and pop. This gives zero idle gap between frames. Otherwise go to IDLE.
- Baud counter: runs 0..CLK_DIVIDER-1 and is cleared at every state entry. The bit boundary is counter == CLK_DIVIDER-1.
- CTS sampling: `uart_cts` is sampled only at frame-start decisions. Deassertion mid-frame never aborts or stretches the current frame.
- Output register: `uart_tx` is a registered output, so it has no combinational path from inputs.
- Reset (`areset` async, or `srst` sync) puts the block in this state:
  - FSM in IDLE, FIFO pointers at 0, shift register and counters at 0.
  - `uart_tx`=1, `busy`=0, `fifo_empty`=1, `data_ready`=1.
- Reset mid-frame: the line returns high immediately on `areset`, or on the next edge for `srst`. The partial frame is abandoned and FIFO contents are discarded.

## Timing
- Start latency: if the FIFO is empty and `uart_cts`=1, a push at edge N makes `fifo_empty`=0 after N. The IDLE→START transition occurs at N+1, and `uart_tx` falls after edge N+1.
- Frame length: exactly 10·CLK_DIVIDER cycles (1 start, 8 data, 1 stop).
- Back-to-back frames: the falling edge of frame k+1's start bit follows frame k's stop bit with no extra cycle.
- `busy` rises with the START entry and falls on the STOP→IDLE edge.
- `data_ready` deasserts on the edge where the FIFO count reaches FIFO_DEPTH. It reasserts on the edge after the pop that frees a slot.
- Simultaneous push and pop while not full: both take effect and the count is unchanged.

## Test plan
- **Single byte** (CLK_DIVIDER=8, `uart_cts`=1): push 0xA5. Line shows 0 for 8 cycles, then bits 1,0,1,0,0,1,0,1 with 8 cycles each, then 1 for 8 cycles. `busy` is high for exactly 80 cycles, and `fifo_empty`=1 afterwards.
- **Flow-control hold and fill**: with `uart_cts`=0, push 0x01..0x04. `data_ready`=0 after the 4th push and a 5th push (0x05) is not accepted. `uart_tx` stays 1 and `busy` stays 0. Raise `uart_cts`: 4 contiguous frames 0x01..0x04 take 320 cycles with no idle gap, and `data_ready` returns to 1 after the first pop.
- **CTS drop mid-frame**: start 0x3C and 0xC3 with `uart_cts`=1. Drop `uart_cts` during bit 3 of the first frame. Frame 0x3C completes intact, the FSM returns to IDLE, and 0xC3 stays queued. Raising `uart_cts` sends 0xC3.
- **Simultaneous push/pop**: the FIFO holds 2 bytes and a push coincides with the STOP→START pop. The count stays 2 and the byte order is preserved.
- **Async reset mid-frame**: assert `areset` during the DATA state of frame 0x55 with 2 bytes queued. `uart_tx`=1 and `busy`=0 immediately, and `fifo_empty`=1. After release, no frame is emitted until a new push.
- **srst**: the same scenario with `srst` gives the same result one edge later. A push of 0x80 then produces a correct frame.
